// File: rtl/matmul_seq_ctrl.sv
// Sequential NxN matrix multiplier controller: one 8x8 MAC per cycle, results streamed
// over valid/ready. Define MATMUL_SAT_EN to saturate the accumulator instead of wrapping.

module sixtnbit_multiplier (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  assign p_o = 16'(a_i) * 16'(b_i);
endmodule

module matmul_seq_ctrl #(
  parameter  int unsigned N     = 2,
  parameter  int unsigned ACC_W = 18,
  localparam int unsigned AW    = $clog2(N * N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             start,
  output logic             busy,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [AW-1:0]    c_addr,
  output logic [ACC_W-1:0] c_data,
  output logic             c_sat,
  output logic             done
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned NE = N * N;

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d, c_data_q, c_data_d, acc_next;
  logic [AW-1:0]    c_addr_q, c_addr_d;
  logic [7:0]       a_q [NE];
  logic [7:0]       a_d [NE];
  logic [7:0]       b_q [NE];
  logic [7:0]       b_d [NE];
  logic [AW-1:0]    a_idx, b_idx;
  logic [15:0]      prod;
  logic             last_i, last_j, last_k;

  assign last_i = (i_q == IW'(N - 1));
  assign last_j = (j_q == IW'(N - 1));
  assign last_k = (k_q == IW'(N - 1));
  assign a_idx  = AW'(32'(i_q) * N + 32'(k_q));
  assign b_idx  = AW'(32'(k_q) * N + 32'(j_q));

  sixtnbit_multiplier u_mul (
    .a_i (a_q[a_idx]),
    .b_i (b_q[b_idx]),
    .p_o (prod)
  );

`ifdef MATMUL_SAT_EN
  logic [ACC_W:0] sum;
  logic           ovf;
  logic           sat_q, sat_d, c_sat_q, c_sat_d;

  assign sum      = {1'b0, acc_q} + (ACC_W + 1)'(prod);
  assign ovf      = sum[ACC_W];
  assign acc_next = ovf ? '1 : sum[ACC_W-1:0];

  // Sticky overflow flag for the element currently being accumulated.
  always_comb begin
    sat_d   = sat_q;
    c_sat_d = c_sat_q;
    case (state_q)
      StIdle: if (start) sat_d = 1'b0;
      StMac: begin
        sat_d = sat_q | ovf;
        if (last_k) c_sat_d = sat_q | ovf;
      end
      StEmit: if (c_ready) sat_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q   <= 1'b0;
      c_sat_q <= 1'b0;
    end else begin
      sat_q   <= sat_d;
      c_sat_q <= c_sat_d;
    end
  end

  assign c_sat = c_sat_q;
`else
  assign acc_next = acc_q + ACC_W'(prod);
  assign c_sat    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    c_data_d = c_data_q;
    c_addr_d = c_addr_q;
    a_d      = a_q;
    b_d      = b_q;
    case (state_q)
      StIdle: begin
        if (wr_en && (32'(wr_addr) < NE)) begin
          if (wr_sel) b_d[wr_addr] = wr_data;
          else        a_d[wr_addr] = wr_data;
        end
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_next;
        if (last_k) begin
          c_data_d = acc_next;
          c_addr_d = AW'(32'(i_q) * N + 32'(j_q));
          k_d      = '0;
          state_d  = StEmit;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      StEmit: begin
        if (c_ready) begin
          acc_d = '0;
          if (last_i && last_j) begin
            state_d = StDone;
          end else begin
            state_d = StMac;
            if (last_j) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      c_data_q <= '0;
      c_addr_q <= '0;
      for (int unsigned e = 0; e < NE; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      c_data_q <= c_data_d;
      c_addr_q <= c_addr_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign c_valid = (state_q == StEmit);
  assign done    = (state_q == StDone);
  assign c_addr  = c_addr_q;
  assign c_data  = c_data_q;

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer that computes C = A x B for two NxN matrices of unsigned 8-bit elements.
- Time-shares a single sixtnbit_multiplier instance (unsigned 8x8 -> 16), issuing one multiply-accumulate per cycle.
- Holds operand register files loaded through a write port and streams each C element out over a valid/ready interface.
- Sits between the matrix loader/host logic and downstream result consumers in the matrix subsystem.

Parameters:
- N, 2, matrix dimension; legal range 2..8.
- ACC_W, 18, accumulator and result width; must be >= 16 + ceil(log2 N) for exact results without MATMUL_SAT_EN.
- AW, $clog2(N*N), element address width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_addr  in  AW  element address, row*N+col.
- wr_data  in  8  unsigned operand element.
- start  in  1  start request.
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- c_valid  out  1  result element valid.
- c_ready  in  1  consumer accepts the element.
- c_addr  out  AW  result address, row*N+col.
- c_data  out  ACC_W  result element.
- c_sat  out  1  element saturated (see Optional Feature).
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, c_valid, c_sat, done = 0; c_addr, c_data = 0; i, j, k, accumulator = 0; all A/B registers = 0.
- Reset mid-operation aborts immediately. No element is emitted and done does not pulse.
- Operand writes are accepted only in IDLE. wr_en while busy is ignored.
- States: IDLE, MAC, EMIT, DONE.
- IDLE:
  - start=1 -> MAC next cycle, with i=j=k=0, acc=0, busy=1.
  - start while busy is ignored (not queued).
- MAC:
  - Each cycle: acc <= acc + A[i][k]*B[k][j], using the shared multiplier with zero-extended product.
  - k increments each cycle.
  - When k=N-1, the final sum is registered into c_data; c_addr <= i*N+j; next state EMIT; k <= 0.
- EMIT:
  - c_valid=1; c_data, c_addr, c_sat stay stable until c_valid&c_ready.
  - On handshake: c_valid drops the next cycle; acc <= 0.
  - Advance order: j increments first; on wrap, j=0 and i increments.
  - Not last element -> MAC. Last element (i=j=N-1) -> DONE.
- DONE: done=1 for exactly one cycle, busy stays 1; next state IDLE with busy=0.
- Latency with c_ready held high: N*N*(N+1) cycles from the first MAC cycle to the last handshake, plus 1 DONE cycle. For N=2: start accepted in cycle 0, done high in cycle 13.
- Operand registers retain their values after completion, so start can be reissued without reloading.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined:
  - Accumulation saturates at 2^ACC_W-1.
  - c_sat=1 with any element whose true sum exceeded that value; c_sat clears with acc at the next element.
- Undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - c_sat is tied to 0.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start, c_ready=1 -> c_addr 0..3 with c_data 19, 22, 43, 50 in order; done pulses in cycle 13 after start; busy low the cycle after.
- A and B all 255, N=2, ACC_W=18 -> every c_data = 130050, c_sat=0.
- Hold c_ready=0 for 5 cycles when element 1 is presented -> c_valid stays 1 and c_data stays 22 throughout; sequence resumes with 43, then 50.
- Pulse start and wr_en (writing A[0]=99) mid-run -> outputs unchanged from the base case; after done, c_data for a restart still 19, 22, 43, 50.
- Assert rst_n=0 during MAC of element 2 -> all outputs 0 immediately; no done pulse; after release, reloading the base matrices and starting gives the base-case outputs.
- All-255 inputs with ACC_W=16:
  - With MATMUL_SAT_EN: c_data=65535, c_sat=1.
  - Without: c_data=64514, c_sat=0.
